// File: rtl/dms_cp_ctrl.sv
// dms_cp_ctrl: digital charge-pump controller for the DMS CDR loop.
// Majority-votes bang-bang phase-detector decisions over a WIN-decision
// window and fires a fixed-width UP or DN pulse into the loop-filter charge
// pump, followed by a hold-off gap so the filter node can settle.
// Optional lock detector: define DMS_CP_LOCKDET_EN to enable it; otherwise
// the lock output is tied low.
module dms_cp_ctrl #(
    parameter int WIN       = 16,
    parameter int THRESH    = 4,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2,
    parameter int CW        = 6,
    parameter int LOCK_WIN  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          pd_valid,
    input  logic          pd_early,
    input  logic          pd_late,
    output logic          up,
    output logic          dn,
    output logic          busy,
    output logic [CW-1:0] net_vote,
    output logic          lock
);

    // Parameter sanity: the accumulator must hold +/-WIN without wrapping.
    if ((2 ** (CW - 1)) - 1 < WIN) begin : g_cw_check
        $error("dms_cp_ctrl: CW too narrow to hold +/-WIN");
    end
    if (WIN < 2 || WIN > 255) begin : g_win_check
        $error("dms_cp_ctrl: WIN must be 2..255");
    end
    if (THRESH < 1 || THRESH > WIN) begin : g_thresh_check
        $error("dms_cp_ctrl: THRESH must be 1..WIN");
    end
    if (PULSE_CYC < 1 || HOLD_CYC < 0 || LOCK_WIN < 1) begin : g_cyc_check
        $error("dms_cp_ctrl: PULSE_CYC/LOCK_WIN must be >=1, HOLD_CYC >=0");
    end

    localparam int WW = 8;
    localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [WW-1:0]        WIN_LAST   = WW'(WIN - 1);
    localparam logic [PW-1:0]        PULSE_LAST = PW'(PULSE_CYC - 1);
    localparam logic [HW-1:0]        HOLD_LAST  = HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic signed [CW-1:0] THR_POS    = CW'(THRESH);
    localparam logic signed [CW-1:0] THR_NEG    = -THR_POS;

    typedef enum logic [1:0] {
        ACC      = 2'd0,
        PULSE_UP = 2'd1,
        PULSE_DN = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [WW-1:0]         win_cnt, win_nxt;
    logic [PW-1:0]         pulse_cnt, pulse_nxt;
    logic [HW-1:0]         hold_cnt, hold_nxt;
    logic signed [CW-1:0]  net_q, net_nxt;
    logic signed [CW-1:0]  vote, vote_sum;
    logic                  up_nxt, dn_nxt, busy_nxt;
    logic                  window_end, go_up, go_dn;

    // Map one phase-detector decision to +1 / -1 / 0; '1 is -1 in two's complement.
    always_comb begin
        vote = '0;
        if (pd_early && !pd_late) begin
            vote = CW'(1);
        end else if (pd_late && !pd_early) begin
            vote = '1;
        end
    end

    // |vote_sum| <= WIN, which the CW check guarantees fits without wrap.
    assign vote_sum   = net_q + vote;
    assign window_end = (state == ACC) && pd_valid && (win_cnt == WIN_LAST);
    assign go_up      = (vote_sum >= THR_POS);
    assign go_dn      = (vote_sum <= THR_NEG);

    // Next-state, counter and output decode for the pump sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt = state;
        win_nxt   = win_cnt;
        net_nxt   = net_q;
        pulse_nxt = '0;
        hold_nxt  = '0;

        if (!en) begin
            state_nxt = ACC;
            win_nxt   = '0;
            net_nxt   = '0;
        end else begin
            case (state)
                ACC: begin
                    if (pd_valid) begin
                        if (window_end) begin
                            win_nxt = '0;
                            net_nxt = '0;
                            if (go_up) begin
                                state_nxt = PULSE_UP;
                            end else if (go_dn) begin
                                state_nxt = PULSE_DN;
                            end
                        end else begin
                            win_nxt = win_cnt + WW'(1);
                            net_nxt = vote_sum;
                        end
                    end
                end
                PULSE_UP, PULSE_DN: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state_nxt = (HOLD_CYC == 0) ? ACC : HOLD;
                    end else begin
                        pulse_nxt = pulse_cnt + PW'(1);
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = ACC;
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
                default: state_nxt = ACC;
            endcase
        end

        up_nxt   = (state_nxt == PULSE_UP);
        dn_nxt   = (state_nxt == PULSE_DN);
        busy_nxt = (state_nxt != ACC);
    end

    // State, counters and registered pump drives; reset drops the pumps at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            win_cnt   <= '0;
            pulse_cnt <= '0;
            hold_cnt  <= '0;
            net_q     <= '0;
            up        <= 1'b0;
            dn        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state     <= state_nxt;
            win_cnt   <= win_nxt;
            pulse_cnt <= pulse_nxt;
            hold_cnt  <= hold_nxt;
            net_q     <= net_nxt;
            up        <= up_nxt;
            dn        <= dn_nxt;
            busy      <= busy_nxt;
        end
    end

    assign net_vote = net_q;

`ifdef DMS_CP_LOCKDET_EN
    localparam int             LW       = $clog2(LOCK_WIN + 1);
    localparam logic [LW-1:0]  LOCK_MAX = LW'(LOCK_WIN);

    logic [LW-1:0] lock_cnt;
    logic          lock_q;
    logic          pulse_start, quiet_end;

    assign pulse_start = en && window_end && (go_up || go_dn);
    assign quiet_end   = en && window_end && !(go_up || go_dn);

    // Count consecutive pulse-free windows; saturate at LOCK_WIN and flag lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            lock_q   <= 1'b0;
        end else if (!en || pulse_start) begin
            lock_cnt <= '0;
            lock_q   <= 1'b0;
        end else if (quiet_end && (lock_cnt != LOCK_MAX)) begin
            lock_cnt <= lock_cnt + LW'(1);
            lock_q   <= (lock_cnt == LOCK_MAX - LW'(1));
        end
    end

    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_dms_cp_ctrl.sv
// Self-checking bench for dms_cp_ctrl: a vector table for the first
// windows, hand sequences for pulse width, hold-off, enable and reset
// corners, the lock detector, then randomized traffic against a
// window/schedule reference model.
module tb_dms_cp_ctrl;

    localparam int WIN       = 16;
    localparam int THRESH    = 4;
    localparam int PULSE_CYC = 4;
    localparam int HOLD_CYC  = 2;
    localparam int CW        = 6;
    localparam int LOCK_WIN  = 8;
`ifdef DMS_CP_LOCKDET_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, en, pd_valid, pd_early, pd_late;
    logic          up, dn, busy, lock;
    logic [CW-1:0] net_vote;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dms_cp_ctrl #(
        .WIN(WIN), .THRESH(THRESH), .PULSE_CYC(PULSE_CYC),
        .HOLD_CYC(HOLD_CYC), .CW(CW), .LOCK_WIN(LOCK_WIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pd_valid(pd_valid),
        .pd_early(pd_early), .pd_late(pd_late), .up(up), .dn(dn),
        .busy(busy), .net_vote(net_vote), .lock(lock)
    );

    // Reference model: the votes of the open window, a schedule of the
    // pump pattern for each upcoming busy cycle ({up,dn}), and a count of
    // consecutive pulse-free windows.
    int         m_votes[$];
    logic [1:0] m_sched[$];
    int         m_lcnt;

    function automatic void m_reset();
        m_votes.delete();
        m_sched.delete();
        m_lcnt = 0;
    endfunction

    function automatic int m_net();
        int s = 0;
        foreach (m_votes[i]) s += m_votes[i];
        return s;
    endfunction

    function automatic void m_edge(bit t_en, bit pv, bit e, bit l);
        int s;
        if (!t_en) begin
            m_reset();
        end else if (m_sched.size() > 0) begin
            m_sched.delete(0);
        end else if (pv) begin
            m_votes.push_back((e && !l) ? 1 : ((l && !e) ? -1 : 0));
            if (m_votes.size() == WIN) begin
                s = m_net();
                m_votes.delete();
                if (s >= THRESH || s <= -THRESH) begin
                    for (int i = 0; i < PULSE_CYC; i++) m_sched.push_back((s > 0) ? 2'b10 : 2'b01);
                    for (int i = 0; i < HOLD_CYC; i++) m_sched.push_back(2'b00);
                    m_lcnt = 0;
                end else if (m_lcnt < LOCK_WIN) begin
                    m_lcnt++;
                end
            end
        end
    endfunction

    function automatic logic [31:0] m_expect();
        logic [1:0]    ud;
        logic          b, lk;
        logic [CW-1:0] nv;
        ud = (m_sched.size() > 0) ? m_sched[0] : 2'b00;
        b  = (m_sched.size() > 0);
        lk = LOCK_ON && (m_lcnt >= LOCK_WIN);
        nv = CW'(m_net());
        return 32'({ud, b, lk, nv});
    endfunction

    function automatic logic [31:0] dut_obs();
        return 32'({up, dn, busy, lock, net_vote});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive inputs, take one edge, advance the model, settle 1 time unit.
    task automatic drive_edge(input bit t_en, input bit pv, input bit e, input bit l);
        en       = t_en;
        pd_valid = pv;
        pd_early = e;
        pd_late  = l;
        @(posedge clk);
        m_edge(t_en, pv, e, l);
        #1;
    endtask

    task automatic tick(input bit t_en, input bit pv, input bit e, input bit l);
        drive_edge(t_en, pv, e, l);
        check("model", dut_obs(), m_expect());
    endtask

    typedef struct {
        bit en, pv, e, l;
        bit up, dn, busy;
        int net;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit t_en, bit pv, bit e, bit l, bit u, bit d, bit b, int n);
        vec_t v;
        v.en = t_en; v.pv = pv; v.e = e; v.l = l;
        v.up = u; v.dn = d; v.busy = b; v.net = n;
        vecs.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         cnt;
        int         dn_cnt;
        logic       up_seen, busy_seen;
        int         mode;
        int         r;
        bit         re, rl, rpv, ren;
        logic [31:0] exp;

        rst_n = 1'b0; en = 1'b0; pd_valid = 1'b0; pd_early = 1'b0; pd_late = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset", dut_obs(), 32'd0);
        rst_n = 1'b1;

        // First window of 16 early decisions, pulse, hold, and restart.
        repeat (3) add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) add(1, 1, 1, 0, 0, 0, 0, i + 1);
        add(1, 1, 1, 0, 1, 0, 1, 0);
        repeat (3) add(1, 1, 1, 0, 1, 0, 1, 0);
        repeat (2) add(1, 1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, -1);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        foreach (vecs[k]) begin
            drive_edge(vecs[k].en, vecs[k].pv, vecs[k].e, vecs[k].l);
            exp = 32'({vecs[k].up, vecs[k].dn, vecs[k].busy, 1'b0, CW'(vecs[k].net)});
            check("vec", dut_obs(), exp);
        end

        // Idle with enable high and no decisions.
        repeat (10) tick(1, 0, 0, 0);

        // 10 late + 6 early: v = -4, DN exactly PULSE_CYC cycles.
        for (int i = 0; i < 16; i++) tick(1, 1, i >= 10, i < 10);
        dn_cnt  = int'(dn);
        up_seen = up;
        repeat (7) begin
            tick(1, 0, 0, 0);
            dn_cnt += int'(dn);
            up_seen |= up;
        end
        check("dn_width", 32'(dn_cnt), 32'(4));
        check("dn_no_up", 32'(up_seen), 32'd0);

        // 9 late + 7 early: v = -2, no pulse, window restarts.
        for (int i = 0; i < 16; i++) tick(1, 1, i >= 9, i < 9);
        check("weak_window", 32'({busy, up, dn, net_vote}), 32'd0);
        busy_seen = 1'b0;
        repeat (3) begin
            tick(1, 0, 0, 0);
            busy_seen |= busy;
        end
        check("weak_no_busy", 32'(busy_seen), 32'd0);
        tick(1, 1, 1, 0);
        check("window_restart", 32'(net_vote), 32'd1);
        tick(0, 0, 0, 0);

        // pd_valid held through pulse and hold: 16 fresh decisions needed after busy falls.
        for (int i = 0; i < 16; i++) tick(1, 1, 1, 0);
        check("pulse_start", 32'(up), 32'd1);
        cnt = 0;
        while (busy && cnt < 20) begin
            tick(1, 1, 1, 0);
            cnt++;
        end
        check("busy_fall", 32'(busy), 32'd0);
        cnt = 0;
        while (!up && cnt < 40) begin
            tick(1, 1, 1, 0);
            cnt++;
        end
        check("refill_16", 32'(cnt), 32'd16);
        repeat (8) tick(1, 0, 0, 0);

        // en dropped on the 2nd cycle of an UP pulse.
        for (int i = 0; i < 16; i++) tick(1, 1, 1, 0);
        tick(1, 1, 1, 0);
        check("up_2nd", 32'(up), 32'd1);
        tick(0, 1, 1, 0);
        check("en_drop", 32'({up, dn, busy, net_vote}), 32'd0);
        repeat (3) tick(1, 0, 0, 0);

        // Asynchronous reset in the middle of a DN pulse.
        for (int i = 0; i < 16; i++) tick(1, 1, 0, 1);
        tick(1, 0, 0, 0);
        check("dn_before_rst", 32'(dn), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_dn", dut_obs(), 32'd0);
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick(1, 0, 0, 0);

        // Lock detector: 8 balanced windows, then one all-early window.
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < 16; i++) tick(1, 1, (i % 2) == 0, (i % 2) == 1);
            if (w == 6) check("lock_before", 32'(lock), 32'd0);
            if (w == 7) check("lock_after", 32'(lock), 32'(LOCK_ON));
        end
        for (int i = 0; i < 15; i++) tick(1, 1, 1, 0);
        check("lock_held", 32'(lock), 32'(LOCK_ON));
        tick(1, 1, 1, 0);
        check("lock_clear", 32'({up, lock}), 32'b10);
        repeat (8) tick(1, 0, 0, 0);

        // Randomized traffic with drifting early/late bias.
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) mode = int'($urandom_range(0, 2));
            r   = int'($urandom_range(0, 99));
            rpv = ($urandom_range(0, 99) < 70);
            ren = ($urandom_range(0, 199) != 0);
            case (mode)
                0:       begin re = (r < 75); rl = (r >= 65); end
                1:       begin rl = (r < 75); re = (r >= 65); end
                default: begin re = (r < 45); rl = (r >= 55) || (r < 10); end
            endcase
            tick(ren, rpv, re, rl);
            check("up_dn_excl", 32'(up & dn), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
